// File: rtl/program_loader.sv
// Boot-time loader: turns a header-prefixed byte stream into 32-bit instruction
// memory writes and holds the CPU in reset until the whole program is written.
module program_loader #(
  parameter int DEPTH_W    = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               LoadInstructions,
  output logic [31:0]        Instruction,
  output logic [31:0]        LoadAddress,
  output logic               CpuReset,
  output logic               done,
  output logic               err,
  output logic [DEPTH_W:0]   words_loaded
);

  typedef enum logic [2:0] {Idle, Hdr0, Hdr1, Data, Write, Done} stateT;

  localparam logic [16:0] Capacity = 17'(1) << DEPTH_W;

  stateT       state;
  logic [15:0] count;
  logic [1:0]  byteCnt;
  logic [31:0] shiftReg;

  logic        accept;
  logic [31:0] nextWord;
  logic [15:0] hdrCount;
  logic [16:0] wordsNext;

  assign accept    = byte_valid & byte_ready;
  assign nextWord  = BIG_ENDIAN ? {shiftReg[23:0], byte_in} : {byte_in, shiftReg[31:8]};
  assign hdrCount  = {count[15:8], byte_in};
  assign wordsNext = 17'(words_loaded) + 17'd1;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state            <= Idle;
      count            <= '0;
      byteCnt          <= '0;
      shiftReg         <= '0;
      byte_ready       <= 1'b0;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      LoadAddress      <= '0;
      CpuReset         <= 1'b1;
      done             <= 1'b0;
      err              <= 1'b0;
      words_loaded     <= '0;
    end else begin
      // NOTE: non-blocking default makes the strobe exactly one cycle; the
      // branch below that enters Write overrides it for that single edge.
      LoadInstructions <= 1'b0;
      case (state)
        Idle, Done: begin
          if (start) begin
            state        <= Hdr0;
            byte_ready   <= 1'b1;
            CpuReset     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byteCnt      <= '0;
          end
        end
        Hdr0: begin
          if (accept) begin
            count[15:8] <= byte_in;
            state       <= Hdr1;
          end
        end
        Hdr1: begin
          if (accept) begin
            count <= hdrCount;
            if (hdrCount == 16'd0 || {1'b0, hdrCount} > Capacity) begin
              err        <= (hdrCount != 16'd0);
              state      <= Done;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              CpuReset   <= 1'b0;
            end else begin
              state <= Data;
            end
          end
        end
        Data: begin
          if (accept) begin
            shiftReg <= nextWord;
            byteCnt  <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              state            <= Write;
              byte_ready       <= 1'b0;
              LoadInstructions <= 1'b1;
              Instruction      <= nextWord;
              LoadAddress      <= 32'(words_loaded[DEPTH_W-1:0]);
            end
          end
        end
        Write: begin
          words_loaded <= wordsNext[DEPTH_W:0];
          if (wordsNext == 17'(count)) begin
            state    <= Done;
            done     <= 1'b1;
            CpuReset <= 1'b0;
          end else begin
            state      <= Data;
            byte_ready <= 1'b1;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench: one big-endian and one little-endian loader share the same
// stream; expected writes are queued as bytes are sent and popped on each strobe.
module tb_program_loader;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       Reset, start, byte_valid;
  logic [7:0] byte_in;

  logic          rdyBe, liBe, cpuBe, doneBe, errBe;
  logic [31:0]   insBe, addrBe;
  logic [DW:0]   wlBe;
  logic          rdyLe, liLe, cpuLe, doneLe, errLe;
  logic [31:0]   insLe, addrLe;
  logic [DW:0]   wlLe;

  always #5 clk = ~clk;

  program_loader #(.DEPTH_W(DW), .BIG_ENDIAN(1'b1)) dutBe (
    .clk(clk), .Reset(Reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdyBe), .LoadInstructions(liBe), .Instruction(insBe), .LoadAddress(addrBe),
    .CpuReset(cpuBe), .done(doneBe), .err(errBe), .words_loaded(wlBe)
  );

  program_loader #(.DEPTH_W(DW), .BIG_ENDIAN(1'b0)) dutLe (
    .clk(clk), .Reset(Reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdyLe), .LoadInstructions(liLe), .Instruction(insLe), .LoadAddress(addrLe),
    .CpuReset(cpuLe), .done(doneLe), .err(errLe), .words_loaded(wlLe)
  );

  int checksTotal = 0;
  int checksPassed = 0;
  int strobesBe = 0;
  int strobesLe = 0;
  logic [63:0] qBe[$];
  logic [63:0] qLe[$];
  logic [63:0] expBe, expLe;
  logic [31:0] prog[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Unexpected strobes compare against an all-ones address that can never occur.
  always @(negedge clk) begin
    if (liBe) begin
      strobesBe++;
      expBe = (qBe.size() > 0) ? qBe.pop_front() : '1;
      check("be_strobe", {addrBe, insBe}, expBe);
    end
    if (liLe) begin
      strobesLe++;
      expLe = (qLe.size() > 0) ? qLe.pop_front() : '1;
      check("le_strobe", {addrLe, insLe}, expLe);
    end
  end

  // All tasks start and end on a falling edge.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit taken = 1'b0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50 && !taken; t++) begin
      taken = rdyBe;
      @(negedge clk);
    end
    if (!taken) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic sendWord(input logic [31:0] w, input int idx, input int maxGap);
    qBe.push_back({32'(idx), w});
    qLe.push_back({32'(idx), bswap(w)});
    for (int b = 0; b < 4; b++) sendByte(w[31-8*b -: 8], $urandom_range(0, maxGap));
  endtask

  task automatic startLoad(input logic [15:0] cnt);
    strobesBe = 0;
    strobesLe = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_cpureset", cpuBe, 1);
    check("start_done", doneBe, 0);
    check("start_ready", {rdyBe, rdyLe}, 2'b11);
    check("start_err_cleared", errBe, 0);
    check("start_words_cleared", wlBe, 0);
    sendByte(cnt[15:8], 0);
    sendByte(cnt[7:0], 0);
  endtask

  task automatic runProgram(input int maxGap);
    startLoad(16'(prog.size()));
    foreach (prog[i]) sendWord(prog[i], i, maxGap);
    byte_valid = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 20 && !doneBe; i++) @(negedge clk);
  endtask

  task automatic finishChecks(input string tag, input int nWords, input bit expErr);
    check({tag, "_done"}, {doneBe, doneLe}, 2'b11);
    check({tag, "_cpureset"}, {cpuBe, cpuLe}, 2'b00);
    check({tag, "_err"}, {errBe, errLe}, {expErr, expErr});
    check({tag, "_ready"}, {rdyBe, rdyLe}, 2'b00);
    check({tag, "_words_be"}, wlBe, nWords);
    check({tag, "_words_le"}, wlLe, nWords);
    check({tag, "_strobes_be"}, strobesBe, nWords);
    check({tag, "_strobes_le"}, strobesLe, nWords);
    check({tag, "_queue_drained"}, qBe.size() + qLe.size(), 0);
    if (nWords > 0) begin
      check({tag, "_instr_hold"}, {insBe, insLe}, {prog[nWords-1], bswap(prog[nWords-1])});
      check({tag, "_addr_hold"}, addrBe, nWords - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", rdyBe, 0);
    check("reset_strobe", liBe, 0);
    check("reset_instr", insBe, 0);
    check("reset_addr", addrBe, 0);
    check("reset_cpureset", cpuBe, 1);
    check("reset_done_err", {doneBe, errBe}, 2'b00);
    check("reset_words", wlBe, 0);
    Reset = 1'b0;
    @(negedge clk);
    check("idle_holds_cpu", {cpuBe, rdyBe}, 2'b10);

    // Reference two-word program, continuous stream.
    prog = '{32'h20080005, 32'h01095020};
    runProgram(0);
    waitDone();
    finishChecks("two_words", 2, 1'b0);

    // Restart from DONE with random valid gaps on a 16-word program.
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back($urandom);
    runProgram(7);
    waitDone();
    finishChecks("gapped16", 16, 1'b0);

    // Oversize header: done the cycle after the second header byte.
    prog.delete();
    startLoad(16'd257);
    byte_valid = 1'b0;
    finishChecks("oversize257", 0, 1'b1);

    // Exactly full capacity.
    for (int i = 0; i < 256; i++) prog.push_back($urandom);
    runProgram(0);
    waitDone();
    finishChecks("full256", 256, 1'b0);

    // Empty program.
    prog.delete();
    startLoad(16'd0);
    byte_valid = 1'b0;
    finishChecks("empty", 0, 1'b0);

    // Reset in the middle of word 3, then a fresh one-word program.
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back($urandom);
    startLoad(16'd5);
    for (int i = 0; i < 3; i++) sendWord(prog[i], i, 1);
    sendByte(prog[3][31:24], 0);
    sendByte(prog[3][23:16], 0);
    byte_valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("async_reset_ready", {rdyBe, rdyLe}, 2'b00);
    check("async_reset_cpu", {cpuBe, cpuLe}, 2'b11);
    check("async_reset_words", wlBe, 0);
    check("async_reset_outputs", {liBe, doneBe, errBe, insBe, addrBe}, 0);
    check("pre_reset_strobes", strobesBe, 3);
    @(negedge clk);
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_no_strobe", strobesBe, 3);
    qBe.delete();
    qLe.delete();
    prog = '{32'hCAFEF00D};
    runProgram(2);
    waitDone();
    finishChecks("after_reset", 1, 1'b0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader sitting directly upstream of the pipelined CPU's instruction-memory load port. It accepts a byte stream (2-byte header plus program body) over a valid/ready handshake, assembles 32-bit instruction words, and writes each one with a one-cycle LoadInstructions strobe, an explicit word address and the assembled Instruction. The CPU is held in reset until the whole program is written; the CPU is then released.

## Interface
- DEPTH_W, 8: address width in words; capacity 2^DEPTH_W words.
- BIG_ENDIAN, 1: 1 = first body byte is bits [31:24]; 0 = first body byte is bits [7:0].

- clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled in IDLE and DONE only.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- LoadInstructions  out  1  one-cycle write strobe to instruction memory.
- Instruction  out  32  assembled word; valid while LoadInstructions=1.
- LoadAddress  out  32  word index being written, zero-extended from DEPTH_W bits.
- CpuReset  out  1  holds the CPU in reset while high.
- done  out  1  load finished (high in DONE).
- err  out  1  header count exceeded capacity; sticky until next start or Reset.
- words_loaded  out  DEPTH_W+1  number of words written in the current/last load.

## Operation
- All outputs registered. Reset values: byte_ready 0, LoadInstructions 0, Instruction 0, LoadAddress 0, CpuReset 1, done 0, err 0, words_loaded 0; state IDLE.
- Byte transfer occurs on a cycle with byte_valid=1 and byte_ready=1; byte_ready is high only in HDR0, HDR1, DATA.
- States:
  - IDLE: CpuReset=1. start=1 -> HDR0; clear err, words_loaded, byte counter.
  - HDR0: accepted byte -> count[15:8]; -> HDR1.
  - HDR1: accepted byte -> count[7:0]. count=0 -> DONE. count>2^DEPTH_W -> err=1, -> DONE (no writes). Else -> DATA.
  - DATA: accept bytes into shift register per BIG_ENDIAN; on 4th byte -> WRITE.
  - WRITE: LoadInstructions=1 for exactly this cycle, Instruction=assembled word, LoadAddress=words_loaded; on exit words_loaded+1; words_loaded+1==count -> DONE, else -> DATA.
  - DONE: done=1, CpuReset=0, byte_ready=0. start=1 -> HDR0 with CpuReset=1, done=0, err cleared.
- Bytes arriving in IDLE/DONE/WRITE are not accepted (byte_ready=0); the source must hold them.
- start outside IDLE/DONE is ignored.
- Header count is 16-bit, unsigned; comparison done at 17 bits so 2^DEPTH_W itself is legal.
- Instruction and LoadAddress hold their last written values outside WRITE.

## Timing
- start in IDLE at edge k -> byte_ready=1 from cycle k+1.
- Fourth body byte accepted at edge k -> LoadInstructions=1 during cycle k+1 -> byte_ready=1 again cycle k+2. Peak throughput: 1 word per 5 cycles.
- Last WRITE cycle at k -> done=1, CpuReset=0 from cycle k+1.
- Header count 0 or oversize: done=1 the cycle after the second header byte is accepted.
- Reset asserted at any point (mid-header, mid-word, during WRITE): outputs take reset values immediately (asynchronous); partial word discarded; no strobe issued; CpuReset=1.
- byte_valid gaps of any length in DATA: assembly pauses, byte order preserved.

## Test plan
- BIG_ENDIAN=1, stream 00 02 | 20 08 00 05 | 01 09 50 20 continuous: two strobes, (addr 0, 0x20080005) and (addr 1, 0x01095020); done=1, CpuReset=0, words_loaded=2.
- Same body with BIG_ENDIAN=0: words 0x05000820 and 0x20500901.
- Random byte_valid gaps (0-7 idle cycles) on a 16-word load: identical words/addresses as gap-free run; no strobe when a word is incomplete.
- Header 01 01 (257) with DEPTH_W=8: err=1, done=1, zero strobes; header 01 00 (256): 256 strobes, err=0.
- Header 00 00: done=1 next cycle, no strobes, CpuReset=0.
- Reset after 2 bytes of word 3, then restart with new 1-word program: no strobe for the partial word, next strobe at address 0; start in DONE re-raises CpuReset and reloads.
